// File: rtl/obsidian_decode_stage.sv
// Instruction decode stage: register file with write-through bypass, opcode
// decode, load-use hazard detection and the ID/EX pipeline register.
module obsidian_decode_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  IF_ID,
  input  logic [37:0]  WB_ID,
  input  logic         flush,
  output logic         stall,
  output logic [116:0] ID_EX
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  opcode_e     opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm;

  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;

  logic [31:0] regs [32];
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic [5:0]  ctrl;
  logic [4:0]  dest;
  logic        uses_rt;
  logic [116:0] decoded;

  assign opcode  = opcode_e'(IF_ID[31:26]);
  assign rs      = IF_ID[25:21];
  assign rt      = IF_ID[20:16];
  assign rd      = IF_ID[15:11];
  assign imm     = {{16{IF_ID[15]}}, IF_ID[15:0]};

  assign wb_en   = WB_ID[37];
  assign wb_data = WB_ID[36:5];
  assign wb_dst  = WB_ID[4:0];

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (wb_dst != 5'd0)) begin
      regs[wb_dst] <= wb_data;
    end
  end

  // Reads see a writeback landing on the same edge.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != 5'd0) begin
      rs_data = (wb_en && (wb_dst == rs)) ? wb_data : regs[rs];
    end
    if (rt != 5'd0) begin
      rt_data = (wb_en && (wb_dst == rt)) ? wb_data : regs[rt];
    end
  end

  // ctrl = {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch}
  always_comb begin
    ctrl    = '0;
    dest    = '0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin ctrl = 6'b100000; dest = rd; uses_rt = 1'b1; end
      OP_LW:    begin ctrl = 6'b111010; dest = rt; end
      OP_SW:    begin ctrl = 6'b000110; uses_rt = 1'b1; end
      OP_ADDI:  begin ctrl = 6'b100010; dest = rt; end
      OP_BEQ:   begin ctrl = 6'b000001; uses_rt = 1'b1; end
      default:  begin ctrl = '0; dest = '0; end
    endcase
  end

  assign decoded = {ctrl, rs_data, rt_data, imm, rs, rt, dest};

  assign stall = ID_EX[114] && (ID_EX[4:0] != 5'd0) &&
                 ((ID_EX[4:0] == rs) || (uses_rt && (ID_EX[4:0] == rt)));

  // A bubble clears only controls and destination; data fields are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX <= '0;
    end else if (flush || stall) begin
      ID_EX <= {6'b000000, decoded[110:5], 5'b00000};
    end else begin
      ID_EX <= decoded;
    end
  end

endmodule

// File: tb/tb_obsidian_decode_stage.sv
// Scoreboard bench for obsidian_decode_stage: the driver predicts each cycle's
// stall and ID_EX from a behavioural model; a monitor pops and compares.
module tb_obsidian_decode_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  IF_ID;
  logic [37:0]  WB_ID;
  logic         flush;
  logic         stall;
  logic [116:0] ID_EX;

  obsidian_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .IF_ID (IF_ID),
    .WB_ID (WB_ID),
    .flush (flush),
    .stall (stall),
    .ID_EX (ID_EX)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         stall;
    logic         bubble;
    logic [116:0] idex;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] rf [32];
  logic        m_memread;
  logic [4:0]  m_dest;

  function automatic logic [31:0] mk_r(input int s, input int t, input int d);
    logic [4:0] s5, t5, d5;
    s5 = 5'(s); t5 = 5'(t); d5 = 5'(d);
    return {6'b000000, s5, t5, d5, 11'h020};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input int s, input int t,
                                       input logic [15:0] im);
    logic [4:0] s5, t5;
    s5 = 5'(s); t5 = 5'(t);
    return {op, s5, t5, im};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic [37:0] wb);
    if (r == 0) return 32'd0;
    if (wb[37] && wb[4:0] == r) return wb[36:5];
    return rf[r];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    m_memread = 1'b0;
    m_dest    = 5'd0;
  endfunction

  // One cycle of stimulus; expectation is pushed for the monitor.
  task automatic drive(input logic [31:0] instr, input logic [37:0] wb, input logic fl,
                       output logic st);
    logic [5:0]  op;
    logic [4:0]  s, t, d;
    logic [5:0]  c;
    logic        reads_rt;
    exp_t        e;
    @(negedge clk);
    IF_ID = instr;
    WB_ID = wb;
    flush = fl;
    op = instr[31:26];
    s  = instr[25:21];
    t  = instr[20:16];
    c  = 6'd0;
    d  = 5'd0;
    reads_rt = 1'b0;
    if (op == 6'b000000) begin c = 6'b100000; d = instr[15:11]; reads_rt = 1'b1; end
    else if (op == 6'b100011) begin c = 6'b111010; d = t; end
    else if (op == 6'b101011) begin c = 6'b000110; reads_rt = 1'b1; end
    else if (op == 6'b001000) begin c = 6'b100010; d = t; end
    else if (op == 6'b000100) begin c = 6'b000001; reads_rt = 1'b1; end
    st = m_memread && (m_dest != 0) && (m_dest == s || (reads_rt && m_dest == t));
    e.stall  = st;
    e.bubble = st || fl;
    e.idex   = {c, model_read(s, wb), model_read(t, wb),
                {{16{instr[15]}}, instr[15:0]}, s, t, d};
    q.push_back(e);
    if (e.bubble) begin
      m_memread = 1'b0;
      m_dest    = 5'd0;
    end else begin
      m_memread = c[3];
      m_dest    = d;
    end
    if (wb[37] && wb[4:0] != 0) rf[wb[4:0]] = wb[36:5];
  endtask

  // Issue an instruction, holding it while the stage stalls; returns stall cycles.
  task automatic issue(input logic [31:0] instr, input logic [37:0] wb, input logic fl,
                       output int stalls);
    logic st;
    stalls = 0;
    drive(instr, wb, fl, st);
    while (st && stalls < 4) begin
      stalls++;
      drive(instr, 38'd0, 1'b0, st);
    end
    if (st) begin
      n_vec++; n_err++;
      $display("FAIL stall_bound: stall still high after %0d cycles, required low", stalls);
    end
  endtask

  task automatic rand_cycle();
    logic [31:0] instr;
    logic [37:0] wb;
    logic [5:0]  op;
    int          sel, stalls;
    sel = $urandom_range(0, 5);
    case (sel)
      0: op = 6'b000000;
      1: op = 6'b100011;
      2: op = 6'b101011;
      3: op = 6'b001000;
      4: op = 6'b000100;
      default: op = 6'($urandom_range(9, 63));
    endcase
    instr = $urandom;
    instr[31:26] = op;
    instr[25:21] = 5'($urandom_range(0, 7));
    instr[20:16] = 5'($urandom_range(0, 7));
    instr[15:11] = 5'($urandom_range(0, 7));
    wb = {1'($urandom_range(0, 1)), 32'($urandom), 5'($urandom_range(0, 7))};
    issue(instr, wb, ($urandom_range(0, 9) == 0), stalls);
  endtask

  // Monitor: stall mid-low-phase, ID_EX just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q[0];
        n_vec++;
        if (stall !== e.stall) begin
          n_err++;
          $display("FAIL stall: got %b, required %b (t=%0t)", stall, e.stall, $time);
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        n_vec++;
        if (e.bubble) begin
          if ({ID_EX[116:111], ID_EX[4:0]} !== 11'd0) begin
            n_err++;
            $display("FAIL bubble: ctrl=%b dest=%0d, required ctrl=0 dest=0 (t=%0t)",
                     ID_EX[116:111], ID_EX[4:0], $time);
          end
        end else if (ID_EX !== e.idex) begin
          n_err++;
          $display("FAIL id_ex: got %h, required %h (t=%0t)", ID_EX, e.idex, $time);
        end
      end
    end
  end

  initial begin
    int   stalls;
    logic st;
    rst_n = 1'b0;
    IF_ID = '0;
    flush = 1'b0;
    WB_ID = {1'b1, 32'hCAFEF00D, 5'd3};
    model_reset();
    @(posedge clk);
    #1;
    n_vec++;
    if (ID_EX !== 117'd0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: ID_EX=%h stall=%b, required 0 and 0", ID_EX, stall);
    end
    WB_ID = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // write then read
    issue(mk_i(6'h3F, 0, 0, 16'h0), {1'b1, 32'hDEADBEEF, 5'd3}, 1'b0, stalls);
    issue(mk_r(3, 0, 4), 38'd0, 1'b0, stalls);
    // same-cycle bypass into SW
    issue(mk_i(6'b101011, 1, 7, 16'h0010), {1'b1, 32'h12345678, 5'd7}, 1'b0, stalls);
    // register 0 write is discarded
    issue(mk_i(6'h3F, 0, 0, 16'h0), {1'b1, 32'hFFFFFFFF, 5'd0}, 1'b0, stalls);
    issue(mk_r(0, 0, 1), 38'd0, 1'b0, stalls);
    // load-use: exactly one stall cycle
    issue(mk_i(6'b100011, 1, 5, 16'h0004), 38'd0, 1'b0, stalls);
    issue(mk_r(5, 2, 6), 38'd0, 1'b0, stalls);
    n_vec++;
    if (stalls != 1) begin
      n_err++;
      $display("FAIL load_use_len: got %0d stall cycles, required 1", stalls);
    end
    // flush while stalled
    issue(mk_i(6'b100011, 2, 6, 16'h0008), 38'd0, 1'b0, stalls);
    drive(mk_r(6, 1, 7), 38'd0, 1'b1, st);
    // sign extension
    issue(mk_i(6'b001000, 1, 9, 16'h8001), 38'd0, 1'b0, stalls);

    for (int i = 0; i < 400; i++) rand_cycle();

    // asynchronous reset mid-operation, with a coincident write to r3
    issue(mk_i(6'h3F, 0, 0, 16'h0), {1'b1, 32'hA5A5A5A5, 5'd3}, 1'b0, stalls);
    issue(mk_i(6'b100011, 0, 3, 16'h0), 38'd0, 1'b0, stalls);
    @(negedge clk);
    IF_ID = mk_r(3, 3, 8);
    WB_ID = {1'b1, 32'h5A5A5A5A, 5'd3};
    flush = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (ID_EX !== 117'd0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: ID_EX=%h stall=%b, required 0 and 0", ID_EX, stall);
    end
    model_reset();
    @(posedge clk);
    WB_ID = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue(mk_r(3, 0, 4), 38'd0, 1'b0, stalls);

    for (int i = 0; i < 100; i++) rand_cycle();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d expectations pending, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/obsidian_decode_stage.md
OBSIDIAN_DECODE_STAGE -- requirements
Module: obsidian_decode_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port IF_ID, input, 32 bits: instruction word. [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
REQ-004 SHALL have port WB_ID, input, 38 bits: writeback bus. [37] RegWrite, [36:5] write data, [4:0] destination register.
REQ-005 SHALL have port flush, input, 1 bit: convert the instruction being latched this cycle into a bubble.
REQ-006 SHALL have port stall, output, 1 bit: load-use hazard detected; combinational; upstream holds IF_ID while it is high.
REQ-007 SHALL have port ID_EX, output reg, 117 bits: pipeline register with these fields.
- [116] RegWrite, [115] MemtoReg, [114] MemRead, [113] MemWrite, [112] ALUSrc, [111] Branch
- [110:79] rs data, [78:47] rt data, [46:15] sign-extended imm
- [14:10] rs, [9:5] rt, [4:0] destination

Function
REQ-008 SHALL contain 32 x 32-bit registers; register 0 always reads 0; writes to register 0 are discarded.
REQ-009 SHALL write WB_ID[36:5] into register WB_ID[4:0] on posedge clk when WB_ID[37]=1.
REQ-010 SHALL bypass writes within the same cycle: a read of register N returns WB_ID[36:5] when WB_ID[37]=1, WB_ID[4:0]=N and N!=0.
REQ-011 SHALL decode the opcode to controls and destination as follows.
- 000000 (R-type): RegWrite=1; destination=rd.
- 100011 (LW): RegWrite, MemtoReg, MemRead and ALUSrc =1; destination=rt.
- 101011 (SW): MemWrite and ALUSrc =1; destination=0.
- 001000 (ADDI): RegWrite and ALUSrc =1; destination=rt.
- 000100 (BEQ): Branch=1; destination=0.
- Any other opcode: all six controls 0 and destination 0 (NOP); data fields still latched.
REQ-012 SHALL produce imm = {16{IF_ID[15]}, IF_ID[15:0]}.
REQ-013 SHALL drive stall=1 when all of these hold:
- ID_EX[114]=1;
- ID_EX[4:0]!=0;
- ID_EX[4:0] equals IF_ID rs, or equals IF_ID rt for the R-type, SW and BEQ opcodes.
- In all other cases stall=0.
REQ-014 SHALL handle stall as follows: when stall=1 and flush=0, at posedge ID_EX[116:111]<=0 and ID_EX[4:0]<=0 (bubble); all other ID_EX fields are don't-care.
REQ-015 SHALL give flush priority over stall: when flush=1, at posedge ID_EX[116:111]<=0 and ID_EX[4:0]<=0.
REQ-016 SHALL, when stall=0 and flush=0, latch the fully decoded instruction into ID_EX at posedge; latency is 1 cycle from IF_ID to ID_EX.
REQ-017 SHALL perform a register write from WB_ID regardless of stall or flush.
REQ-018 SHALL never let a bubble assert stall in the following cycle, because MemRead=0 in a bubble.

Reset
REQ-019 SHALL, while rst_n=0, asynchronously clear all 32 registers and ID_EX to 0.
REQ-020 SHALL leave stall=0 after reset, since ID_EX[114]=0.
REQ-021 SHALL discard a WB_ID write that coincides with the reset-assert edge.
REQ-022 SHALL accept its first write on the first posedge clk after rst_n rises.

Verification
REQ-023 SHALL cover write then read.
- Stimulus: WB_ID={1,32'hDEADBEEF,5'd3}; next cycle IF_ID=ADD with rs=3, rt=0, rd=4.
- Response: ID_EX[110:79]=32'hDEADBEEF, [116]=1, [4:0]=4.
REQ-024 SHALL cover same-cycle bypass.
- Stimulus: WB_ID writes 32'h12345678 to r7 in the same cycle IF_ID=SW with rt=7.
- Response: ID_EX[78:47]=32'h12345678, [113]=1, [4:0]=0.
REQ-025 SHALL cover register 0 write.
- Stimulus: WB_ID writes 32'hFFFFFFFF to r0; then read r0.
- Response: data=0.
REQ-026 SHALL cover load-use hazard.
- Stimulus: LW with rt=5, then ADD with rs=5.
- Response: stall=1 for exactly one cycle; ID_EX holds a bubble (ctrl=0, dest=0).
- The ADD then latches on the next posedge with stall=0.
REQ-027 SHALL cover flush during stall.
- Stimulus: flush=1 while stall=1.
- Response: bubble latched.
REQ-028 SHALL cover sign extension and reset.
- Stimulus: ADDI with imm=16'h8001.
- Response: ID_EX[46:15]=32'hFFFF8001.
- Stimulus: assert rst_n=0 mid-operation.
- Response: ID_EX=0 immediately and a subsequent read of r3 returns 0.
